// File: rtl/otp_keypad_entry_pkg.sv
// Shared definitions for the OTP keypad entry block: key codes, widths,
// scanner state encoding and the keypad position-to-code map.
package otp_keypad_entry_pkg;

    localparam int unsigned OTP_DIGITS = 4;
    localparam int unsigned OTP_W      = 4 * OTP_DIGITS;
    localparam int unsigned CNT_W      = 3;

    localparam logic [3:0] K_ENTER = 4'hE;
    localparam logic [3:0] K_CLEAR = 4'hC;
    localparam logic [3:0] K_BKSP  = 4'hB;
    localparam logic [3:0] K_NONE  = 4'hF;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_WAIT_REL = 2'd3
    } scan_state_e;

    // Physical layout (rows top to bottom, columns left to right):
    //   1 2 3 -     / 4 5 6 -     / 7 8 9 CLEAR / BKSP 0 ENTER -
    function automatic logic [3:0] keymap(input logic [1:0] col_idx, input logic [1:0] row_idx);
        logic [3:0] code;
        case ({col_idx, row_idx})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd4;
            4'h2:    code = 4'd7;
            4'h3:    code = K_BKSP;
            4'h4:    code = 4'd2;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd8;
            4'h7:    code = 4'd0;
            4'h8:    code = 4'd3;
            4'h9:    code = 4'd6;
            4'hA:    code = 4'd9;
            4'hB:    code = K_ENTER;
            4'hE:    code = K_CLEAR;
            default: code = K_NONE;
        endcase
        return code;
    endfunction

    // Lowest-index active-low row wins when several rows are pulled low.
    function automatic logic [1:0] first_low(input logic [3:0] row);
        logic [1:0] idx;
        if (!row[0])      idx = 2'd0;
        else if (!row[1]) idx = 2'd1;
        else if (!row[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/otp_keypad_entry_if.sv
// Keypad and OTP result bus.
//   row        keypad rows, active-low (from keypad)
//   col        column drive, active-low one-hot (to keypad)
//   user_otp   entered digits, newest in [3:0]
//   user_otp_q submitted OTP, valid while otp_valid is high
//   digit_cnt  digits held, 0..4
//   otp_valid  one-cycle submission strobe
//   key_strobe one-cycle pulse per accepted key press
interface otp_keypad_entry_if;
    import otp_keypad_entry_pkg::*;

    logic [3:0]       row;
    logic [3:0]       col;
    logic [OTP_W-1:0] user_otp;
    logic [OTP_W-1:0] user_otp_q;
    logic [CNT_W-1:0] digit_cnt;
    logic             otp_valid;
    logic             key_strobe;

    modport master (
        input  row,
        output col, user_otp, user_otp_q, digit_cnt, otp_valid, key_strobe
    );

    modport slave (
        output row,
        input  col, user_otp, user_otp_q, digit_cnt, otp_valid, key_strobe
    );

endinterface

// File: rtl/otp_keypad_entry_keypad_scan.sv
// 4x4 keypad scanner: rotates the column drive, synchronises the rows,
// debounces press and release, and emits one key_press pulse per press.
//   clk, rst     clock, synchronous active-high reset
//   row          raw keypad rows (asynchronous, active-low)
//   col          registered column drive, active-low one-hot
//   key_code     decoded key, valid while key_press is high
//   key_press    one-cycle pulse per accepted press
module otp_keypad_entry_keypad_scan
    import otp_keypad_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_press
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

    scan_state_e      state;
    logic [3:0]       row_s1, row_s2;
    logic [1:0]       col_d1, col_d2;
    logic [1:0]       col_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic [3:0]       row_pat;
    logic             tick;
    logic             settled;

    assign tick    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    // col_d2 is the column that produced row_s2; samples taken while the
    // synchroniser still carries another column's rows are skipped.
    assign settled = (col_d2 == col_idx);

    // Synchroniser, scan divider and scan/debounce FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_SCAN;
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            col_d1    <= 2'd0;
            col_d2    <= 2'd0;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            row_pat   <= 4'hF;
            key_code  <= K_NONE;
            key_press <= 1'b0;
        end else begin
            row_s1    <= row;
            row_s2    <= row_s1;
            col_d1    <= col_idx;
            col_d2    <= col_d1;
            div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
            key_press <= 1'b0;

            case (state)
                S_SCAN: begin
                    if (row_s2 != 4'hF) begin
                        // Freeze on the column that actually produced the rows.
                        row_pat <= row_s2;
                        deb_cnt <= '0;
                        col_idx <= col_d2;
                        col     <= col_drive(col_d2);
                        state   <= S_DEBOUNCE;
                    end else if (tick) begin
                        col_idx <= col_idx + 2'd1;
                        col     <= col_drive(col_idx + 2'd1);
                    end
                end

                S_DEBOUNCE: begin
                    if (tick && settled) begin
                        if (row_s2 != row_pat) begin
                            state <= S_SCAN;
                        end else if (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1)) begin
                            state     <= S_PRESSED;
                            key_press <= 1'b1;
                            key_code  <= keymap(col_idx, first_low(row_pat));
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end
                end

                S_PRESSED: begin
                    deb_cnt <= '0;
                    state   <= S_WAIT_REL;
                end

                S_WAIT_REL: begin
                    if (tick && settled) begin
                        if (row_s2 != 4'hF) begin
                            deb_cnt <= '0;
                        end else if (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1)) begin
                            state   <= S_SCAN;
                            col_idx <= col_idx + 2'd1;
                            col     <= col_drive(col_idx + 2'd1);
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end
                end

                default: state <= S_SCAN;
            endcase
        end
    end

endmodule

// File: rtl/otp_keypad_entry.sv
// OTP keypad entry: scans a 4x4 keypad and collects a 4-digit BCD code.
// Digits shift in at [3:0]; BKSP drops the newest digit, CLEAR empties the
// entry, ENTER with four digits pulses otp_valid with the code in user_otp_q.
// Build option: define OTP_AUTOSUBMIT_EN to submit on the fourth digit
// (ENTER then does nothing).
//   clk, rst  clock, synchronous active-high reset
//   bus       otp_keypad_entry_if.master: row in; col, user_otp, user_otp_q,
//             digit_cnt, otp_valid, key_strobe out
module otp_keypad_entry
    import otp_keypad_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input logic                 clk,
    input logic                 rst,
    otp_keypad_entry_if.master  bus
);

`ifdef OTP_AUTOSUBMIT_EN
    localparam bit AUTOSUBMIT = 1'b1;
`else
    localparam bit AUTOSUBMIT = 1'b0;
`endif

    logic [3:0]       key_code;
    logic             key_press;
    logic [OTP_W-1:0] user_otp;
    logic [OTP_W-1:0] user_otp_q;
    logic [CNT_W-1:0] digit_cnt;
    logic             otp_valid;

    otp_keypad_entry_keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .row       (bus.row),
        .col       (bus.col),
        .key_code  (key_code),
        .key_press (key_press)
    );

    // Key actions land the cycle after key_press.
    always_ff @(posedge clk) begin
        if (rst) begin
            user_otp   <= '0;
            user_otp_q <= '0;
            digit_cnt  <= '0;
            otp_valid  <= 1'b0;
        end else begin
            otp_valid <= 1'b0;
            if (key_press) begin
                if (key_code <= 4'd9) begin
                    if (digit_cnt < CNT_W'(OTP_DIGITS)) begin
                        if (AUTOSUBMIT && (digit_cnt == CNT_W'(OTP_DIGITS - 1))) begin
                            otp_valid  <= 1'b1;
                            user_otp_q <= {user_otp[OTP_W-5:0], key_code};
                            user_otp   <= '0;
                            digit_cnt  <= '0;
                        end else begin
                            user_otp  <= {user_otp[OTP_W-5:0], key_code};
                            digit_cnt <= digit_cnt + CNT_W'(1);
                        end
                    end
                end else begin
                    case (key_code)
                        K_BKSP: begin
                            if (digit_cnt != '0) begin
                                user_otp  <= user_otp >> 4;
                                digit_cnt <= digit_cnt - CNT_W'(1);
                            end
                        end
                        K_CLEAR: begin
                            user_otp  <= '0;
                            digit_cnt <= '0;
                        end
                        K_ENTER: begin
                            if (!AUTOSUBMIT && (digit_cnt == CNT_W'(OTP_DIGITS))) begin
                                otp_valid  <= 1'b1;
                                user_otp_q <= user_otp;
                                user_otp   <= '0;
                                digit_cnt  <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.key_strobe = key_press;
    assign bus.user_otp   = user_otp;
    assign bus.user_otp_q = user_otp_q;
    assign bus.digit_cnt  = digit_cnt;
    assign bus.otp_valid  = otp_valid;

endmodule
